// File: rtl/mii_tx_arbiter.sv
// MII transmit arbiter: round-robin grant between the ARP and IP frame sources,
// preamble/SFD generation, payload streaming with underrun signalling, and IFG.
module mii_tx_arbiter #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = 24,
  parameter int CNT_W            = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arp_req,
  input  logic       arp_valid,
  input  logic [3:0] arp_data,
  input  logic       arp_last,
  output logic       arp_gnt,
  output logic       arp_ready,
  input  logic       ip_req,
  input  logic       ip_valid,
  input  logic [3:0] ip_data,
  input  logic       ip_last,
  output logic       ip_gnt,
  output logic       ip_ready,
  output logic [3:0] txd,
  output logic       txctl,
  output logic       tx_er,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    IFG
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_winner_q, last_winner_d;
  logic             arp_gnt_q, arp_gnt_d;
  logic             ip_gnt_q, ip_gnt_d;
  logic [3:0]       txd_q, txd_d;
  logic             txctl_q, txctl_d;
  logic             tx_er_q, tx_er_d;
  logic             underrun_q, underrun_d;

  logic             sel_valid;
  logic [3:0]       sel_data;
  logic             sel_last;
  logic             pick_ip;

  // last_winner_q: 1 means IP won the previous arbitration, so ARP wins a tie.
  assign pick_ip   = ip_req && (!arp_req || !last_winner_q);
  assign sel_valid = arp_gnt_q ? arp_valid : ip_valid;
  assign sel_data  = arp_gnt_q ? arp_data  : ip_data;
  assign sel_last  = arp_gnt_q ? arp_last  : ip_last;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_winner_d = last_winner_q;
    arp_gnt_d     = arp_gnt_q;
    ip_gnt_d      = ip_gnt_q;
    txd_d         = 4'h0;
    txctl_d       = 1'b0;
    tx_er_d       = 1'b0;
    underrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arp_req || ip_req) begin
          state_d       = PREAMBLE;
          cnt_d         = '0;
          arp_gnt_d     = !pick_ip;
          ip_gnt_d      = pick_ip;
          last_winner_d = pick_ip;
        end
      end

      PREAMBLE: begin
        txd_d   = 4'hA;
        txctl_d = 1'b1;
        if (cnt_q == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
          state_d = SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SFD: begin
        txd_d   = 4'hB;
        txctl_d = 1'b1;
        state_d = PAYLOAD;
      end

      PAYLOAD: begin
        txctl_d = 1'b1;
        if (sel_valid) begin
          txd_d = sel_data;
          if (sel_last) begin
            state_d   = IFG;
            cnt_d     = '0;
            arp_gnt_d = 1'b0;
            ip_gnt_d  = 1'b0;
          end
        end else begin
          // Missing data mid-frame: poison the frame on the wire and abandon it.
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = IFG;
          cnt_d      = '0;
          arp_gnt_d  = 1'b0;
          ip_gnt_d   = 1'b0;
        end
      end

      IFG: begin
        if (cnt_q == CNT_W'(IFG_NIBBLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        arp_gnt_d = 1'b0;
        ip_gnt_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_winner_q <= 1'b1;
      arp_gnt_q     <= 1'b0;
      ip_gnt_q      <= 1'b0;
      txd_q         <= 4'h0;
      txctl_q       <= 1'b0;
      tx_er_q       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
      arp_gnt_q     <= arp_gnt_d;
      ip_gnt_q      <= ip_gnt_d;
      txd_q         <= txd_d;
      txctl_q       <= txctl_d;
      tx_er_q       <= tx_er_d;
      underrun_q    <= underrun_d;
    end
  end

  assign arp_gnt   = arp_gnt_q;
  assign ip_gnt    = ip_gnt_q;
  assign arp_ready = arp_gnt_q && (state_q == PAYLOAD);
  assign ip_ready  = ip_gnt_q && (state_q == PAYLOAD);
  assign txd       = txd_q;
  assign txctl     = txctl_q;
  assign tx_er     = tx_er_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Randomized bench for mii_tx_arbiter: a frame-level timeline model predicts every
// output per cycle from the arbitration rule and the fixed preamble/SFD/IFG latencies.
module tb_mii_tx_arbiter;

  localparam int N   = 3000;
  localparam int SZ  = N + 200;
  localparam int PRE = 15;
  localparam int IFG = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arpReq = 1'b0, arpValid = 1'b0, arpLast = 1'b0;
  logic [3:0] arpData = 4'h0;
  logic       ipReq = 1'b0, ipValid = 1'b0, ipLast = 1'b0;
  logic [3:0] ipData = 4'h0;
  logic       arpGnt, arpReady, ipGnt, ipReady;
  logic [3:0] txd;
  logic       txctl, txEr, busy, underrun;

  always #5 clk = ~clk;

  mii_tx_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .arp_req  (arpReq),
    .arp_valid(arpValid),
    .arp_data (arpData),
    .arp_last (arpLast),
    .arp_gnt  (arpGnt),
    .arp_ready(arpReady),
    .ip_req   (ipReq),
    .ip_valid (ipValid),
    .ip_data  (ipData),
    .ip_last  (ipLast),
    .ip_gnt   (ipGnt),
    .ip_ready (ipReady),
    .txd      (txd),
    .txctl    (txctl),
    .tx_er    (txEr),
    .busy     (busy),
    .underrun (underrun)
  );

  // Expected per-cycle outputs; source index 0 is ARP, 1 is IP.
  logic [3:0] eTxd [SZ];
  bit         eCtl [SZ];
  bit         eEr  [SZ];
  bit         eUnd [SZ];
  bit         eBusy[SZ];
  bit         eGnt [2][SZ];
  bit         eRdy [2][SZ];

  bit         hasFrame[2];
  bit         granted [2];
  int         reqCyc  [2];
  int         fLen    [2];
  int         fU      [2];
  int         fIdx    [2];
  logic [3:0] nib     [2][16];
  bit         reqV    [2];
  bit         validV  [2];
  bit         lastV   [2];
  logic [3:0] dataV   [2];

  // Directed frames first: sequential 1..8, a tie, an underrun on nibble 5,
  // a request during payload, and a single-nibble frame.
  int tSrc[5] = '{0, 0, 1, 1, 0};
  int tReq[5] = '{2, 60, 60, 125, 200};
  int tLen[5] = '{8, 6, 10, 4, 1};
  int tU  [5] = '{-1, -1, 4, -1, -1};
  bit tUsed[5];

  int vectors = 0;
  int miscompares = 0;
  int modelNextIdle = 0;
  bit lastWinner = 1'b1;
  int rstAt = -1;
  bit rstDone = 1'b0;

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic loadFrame(input int s, input int c);
    bit found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!found && !tUsed[i] && tSrc[i] == s) begin
        found = 1'b1;
        tUsed[i] = 1'b1;
        reqCyc[s] = tReq[i];
        fLen[s] = tLen[i];
        fU[s] = tU[i];
        for (int j = 0; j < 16; j++) nib[s][j] = (i == 0) ? 4'(j + 1) : 4'($urandom);
        hasFrame[s] = 1'b1;
      end
    end
    if (!found && c >= 250 && c < N - 150) begin
      reqCyc[s] = c + int'($urandom_range(60, 0));
      fLen[s] = int'($urandom_range(12, 1));
      fU[s] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(fLen[s] - 1, 0)) : -1;
      for (int j = 0; j < 16; j++) nib[s][j] = 4'($urandom);
      hasFrame[s] = 1'b1;
    end
  endtask

  // Grant seen at cycle c: gnt from c+1, 15 A + B on the pins from c+2,
  // payload ready from c+17, IFG of 24 cycles, idle again at c+P+41.
  task automatic planFrame(input int c, input int s);
    int p = (fU[s] >= 0) ? fU[s] + 1 : fLen[s];
    for (int t = c + 1; t <= c + p + 40 && t < SZ; t++) begin
      eBusy[t] = 1'b1;
      if (t <= c + PRE + 1 + p) eGnt[s][t] = 1'b1;
      if (t >= c + PRE + 2 && t <= c + PRE + 1 + p) eRdy[s][t] = 1'b1;
      if (t >= c + 2 && t <= c + PRE + 1) begin
        eTxd[t] = 4'hA;
        eCtl[t] = 1'b1;
      end
      if (t == c + PRE + 2) begin
        eTxd[t] = 4'hB;
        eCtl[t] = 1'b1;
      end
      if (t >= c + PRE + 3 && t <= c + PRE + 2 + p) begin
        int j = t - (c + PRE + 3);
        eCtl[t] = 1'b1;
        if (j == fU[s]) begin
          eTxd[t] = 4'h0;
          eEr[t] = 1'b1;
          eUnd[t] = 1'b1;
        end else begin
          eTxd[t] = nib[s][j];
        end
      end
    end
    modelNextIdle = c + p + PRE + IFG + 2;
  endtask

  task automatic clearFrom(input int c);
    for (int t = c; t < SZ; t++) begin
      eTxd[t] = 4'h0;
      eCtl[t] = 1'b0;
      eEr[t] = 1'b0;
      eUnd[t] = 1'b0;
      eBusy[t] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        eGnt[s][t] = 1'b0;
        eRdy[s][t] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int c);
    rst = (c < 2) || (c == rstAt);
    if (c == rstAt) begin
      for (int s = 0; s < 2; s++) begin
        if (granted[s]) begin
          granted[s] = 1'b0;
          hasFrame[s] = 1'b0;
        end
        if (!hasFrame[s]) loadFrame(s, c);
        reqCyc[s] = c + 1;
      end
      clearFrom(c + 1);
      modelNextIdle = c + 1;
      lastWinner = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      if (!hasFrame[s]) loadFrame(s, c);
      if (granted[s]) reqV[s] = 1'($urandom_range(1, 0));
      else reqV[s] = hasFrame[s] && (c >= reqCyc[s]);
    end
    if (!rst && c >= modelNextIdle && (reqV[0] || reqV[1])) begin
      int w;
      if (reqV[0] && reqV[1]) w = lastWinner ? 0 : 1;
      else w = reqV[1] ? 1 : 0;
      lastWinner = (w == 1);
      granted[w] = 1'b1;
      fIdx[w] = 0;
      planFrame(c, w);
      if (!rstDone && c >= 1200) begin
        rstAt = c + 6;
        rstDone = 1'b1;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (granted[s]) begin
        if (eRdy[s][c] && fIdx[s] == fU[s]) begin
          validV[s] = 1'b0;
          lastV[s] = 1'b0;
          dataV[s] = 4'($urandom);
          granted[s] = 1'b0;
          hasFrame[s] = 1'b0;
        end else begin
          validV[s] = 1'b1;
          dataV[s] = nib[s][fIdx[s]];
          lastV[s] = (fIdx[s] == fLen[s] - 1);
          if (eRdy[s][c]) begin
            if (lastV[s]) begin
              granted[s] = 1'b0;
              hasFrame[s] = 1'b0;
            end
            fIdx[s]++;
          end
        end
      end else begin
        validV[s] = 1'($urandom);
        lastV[s] = 1'($urandom);
        dataV[s] = 4'($urandom);
      end
    end
    arpReq = reqV[0];
    arpValid = validV[0];
    arpData = dataV[0];
    arpLast = lastV[0];
    ipReq = reqV[1];
    ipValid = validV[1];
    ipData = dataV[1];
    ipLast = lastV[1];
  endtask

  initial begin
    clearFrom(0);
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      checkOutput($sformatf("pins@%0d", c),
                  {txd, txctl, txEr, underrun, arpGnt, ipGnt, arpReady, ipReady, busy},
                  {eTxd[c], eCtl[c], eEr[c], eUnd[c], eGnt[0][c], eGnt[1][c],
                   eRdy[0][c], eRdy[1][c], eBusy[c]});
      applyStimulus(c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
